// File: rtl/tm1638_pkg.sv
// tm1638_pkg: shared constants, state encoding and helpers for the TM1638 responder emulator.
package tm1638_pkg;

   localparam logic [1:0] C_PFX_DATA = 2'b01;
   localparam logic [1:0] C_PFX_CTRL = 2'b10;
   localparam logic [1:0] C_PFX_ADDR = 2'b11;

   localparam int C_MODE_READ_BIT  = 1;
   localparam int C_MODE_FIXED_BIT = 2;

   localparam int C_RAM_DEPTH = 16;
   localparam int C_ADDR_W    = $clog2(C_RAM_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_WDATA,
      ST_RDATA,
      ST_WAIT_END
   } tm_state_t;

   typedef struct packed {
      logic read_keys;
      logic fixed_addr;
   } tm_mode_t;

   // Address after a RAM write: stays put in fixed mode, otherwise wraps modulo the RAM depth.
   function automatic logic [C_ADDR_W-1:0] next_addr(input logic [C_ADDR_W-1:0] addr,
                                                      input logic fixed_addr);
      return fixed_addr ? addr : C_ADDR_W'(addr + 1'b1);
   endfunction

endpackage

// File: rtl/tm1638_slave_emu_if.sv
// tm1638_slave_emu_if: STB/CLK/DIO pin bundle between a TM1638 master and the responder.
interface tm1638_slave_emu_if;

   logic stb;
   logic sclk;
   logic dio;
   logic dio_drv;
   logic dio_oe;

   modport master (output stb, output sclk, output dio, input dio_drv, input dio_oe);
   modport slave  (input stb, input sclk, input dio, output dio_drv, output dio_oe);

endinterface

// File: rtl/tm1638_in_sync.sv
// tm1638_in_sync: multi-stage synchronizer with rise/fall pulse generation for the pin inputs.
// The reset value matches the idle pin levels so no spurious edges appear after reset.
module tm1638_in_sync #(
   parameter int                 C_SYNC_STAGES = 2,
   parameter int                 C_WIDTH       = 3,
   parameter logic [C_WIDTH-1:0] C_RESET_VAL   = '1
) (
   input  logic               CK_i,
   input  logic               XARST_i,
   input  logic [C_WIDTH-1:0] D_i,
   output logic [C_WIDTH-1:0] LVL_o,
   output logic [C_WIDTH-1:0] RISE_o,
   output logic [C_WIDTH-1:0] FALL_o
);

   logic [C_SYNC_STAGES-1:0][C_WIDTH-1:0] sync_q;
   logic [C_WIDTH-1:0]                    prev_q;

   // Shift the asynchronous pins through the synchronizer chain and keep the previous synced level.
   always_ff @(posedge CK_i or negedge XARST_i) begin
      if (!XARST_i) begin
         sync_q <= {C_SYNC_STAGES{C_RESET_VAL}};
         prev_q <= C_RESET_VAL;
      end else begin
         sync_q <= {sync_q[C_SYNC_STAGES-2:0], D_i};
         prev_q <= sync_q[C_SYNC_STAGES-1];
      end
   end

   assign LVL_o  = sync_q[C_SYNC_STAGES-1];
   assign RISE_o = LVL_o & ~prev_q;
   assign FALL_o = ~LVL_o & prev_q;

endmodule

// File: rtl/tm1638_slave_emu.sv
// tm1638_slave_emu: responder side of the TM1638 STB/CLK/DIO link. Decodes commands,
// holds the 16-byte display RAM and shifts the four key-scan bytes back on reads.
module tm1638_slave_emu
   import tm1638_pkg::*;
#(
   parameter int   C_SYNC_STAGES = 2,
   parameter logic C_IDLE_DIO    = 1'b1
) (
   input  logic                     CK_i,
   input  logic                     XARST_i,
   tm1638_slave_emu_if.slave        bus,
   input  logic [31:0]              KEYS_i,
   output logic [C_RAM_DEPTH*8-1:0] DISP_RAM_o,
   output logic                     DISP_ON_o,
   output logic [2:0]               BRIGHT_o,
   output logic                     RAM_WR_o,
   output logic [7:0]               CMD_o,
   output logic                     CMD_VLD_o
);

   logic [2:0]               sync_lvl;
   logic [2:0]               sync_rise;
   logic [2:0]               sync_fall;
   logic                     stb_rise;
   logic                     stb_fall;
   logic                     sclk_rise;
   logic                     sclk_fall;
   logic                     dio_s;
   logic                     unused_sync;

   tm_state_t                state_q;
   tm_state_t                state_d;
   logic [2:0]               bit_cnt_q;
   logic [7:0]               shift_q;
   logic [7:0]               rx_byte;
   logic                     rx_active;
   logic                     byte_done;
   logic                     cmd_done;
   logic                     do_write;
   logic                     load_tx;
   logic                     shift_tx;
   tm_mode_t                 mode_q;
   logic [C_ADDR_W-1:0]      addr_q;
   logic [C_RAM_DEPTH*8-1:0] ram_q;
   logic [31:0]              tx_q;
   logic                     skip_q;

   tm1638_in_sync #(
      .C_SYNC_STAGES (C_SYNC_STAGES),
      .C_WIDTH       (3),
      .C_RESET_VAL   (3'b111)
   ) u_in_sync (
      .CK_i    (CK_i),
      .XARST_i (XARST_i),
      .D_i     ({bus.dio, bus.sclk, bus.stb}),
      .LVL_o   (sync_lvl),
      .RISE_o  (sync_rise),
      .FALL_o  (sync_fall)
   );

   assign stb_rise    = sync_rise[0];
   assign stb_fall    = sync_fall[0];
   assign sclk_rise   = sync_rise[1];
   assign sclk_fall   = sync_fall[1];
   assign dio_s       = sync_lvl[2];
   assign unused_sync = &{1'b0, sync_lvl[1:0], sync_rise[2], sync_fall[2]};

   // Bits arrive LSB first, so the newest bit enters at the top of the shifter.
   assign rx_byte   = {dio_s, shift_q[7:1]};
   assign rx_active = (state_q == ST_CMD) || (state_q == ST_WDATA);
   assign byte_done = rx_active && sclk_rise && !stb_rise && (bit_cnt_q == 3'd7);
   assign cmd_done  = byte_done && (state_q == ST_CMD);
   assign do_write  = byte_done && (state_q == ST_WDATA) && !mode_q.read_keys;
   assign load_tx   = cmd_done && (rx_byte[7:6] == C_PFX_DATA) && rx_byte[C_MODE_READ_BIT];
   assign shift_tx  = (state_q == ST_RDATA) && sclk_fall && !stb_rise;

   // Frame state register.
   always_ff @(posedge CK_i or negedge XARST_i) begin
      if (!XARST_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode: STB rise always returns to idle, the first byte picks the frame type.
   always_comb begin
      state_d = state_q;
      if (stb_rise) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (stb_fall) state_d = ST_CMD;
            end
            ST_CMD: begin
               if (cmd_done) begin
                  case (rx_byte[7:6])
                     C_PFX_DATA: state_d = rx_byte[C_MODE_READ_BIT] ? ST_RDATA : ST_WAIT_END;
                     C_PFX_ADDR: state_d = ST_WDATA;
                     default:    state_d = ST_WAIT_END;
                  endcase
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   // Bit receiver: counts rising SCLK edges and discards any partial byte outside a frame.
   always_ff @(posedge CK_i or negedge XARST_i) begin
      if (!XARST_i) begin
         bit_cnt_q <= '0;
         shift_q   <= '0;
      end else if (!rx_active || stb_rise) begin
         bit_cnt_q <= '0;
      end else if (sclk_rise) begin
         bit_cnt_q <= bit_cnt_q + 3'd1;
         shift_q   <= rx_byte;
      end
   end

   // Command decode: mode, display control, address pointer and the last-byte report.
   always_ff @(posedge CK_i or negedge XARST_i) begin
      if (!XARST_i) begin
         mode_q    <= '0;
         DISP_ON_o <= 1'b0;
         BRIGHT_o  <= '0;
         addr_q    <= '0;
         CMD_o     <= '0;
         CMD_VLD_o <= 1'b0;
      end else begin
         CMD_VLD_o <= byte_done;
         if (byte_done) CMD_o <= rx_byte;
         if (cmd_done) begin
            case (rx_byte[7:6])
               C_PFX_DATA: begin
                  mode_q.read_keys  <= rx_byte[C_MODE_READ_BIT];
                  mode_q.fixed_addr <= rx_byte[C_MODE_FIXED_BIT];
               end
               C_PFX_CTRL: begin
                  DISP_ON_o <= rx_byte[3];
                  BRIGHT_o  <= rx_byte[2:0];
               end
               C_PFX_ADDR: addr_q <= rx_byte[C_ADDR_W-1:0];
               default: ;
            endcase
         end else if (do_write) begin
            addr_q <= next_addr(addr_q, mode_q.fixed_addr);
         end
      end
   end

   // Display RAM write port with a one-cycle write strobe aligned to CMD_VLD_o.
   always_ff @(posedge CK_i or negedge XARST_i) begin
      if (!XARST_i) begin
         ram_q    <= '0;
         RAM_WR_o <= 1'b0;
      end else begin
         RAM_WR_o <= do_write;
         if (do_write) ram_q[{addr_q, 3'b000} +: 8] <= rx_byte;
      end
   end

   // Key transmit shifter: the first falling edge after the command is skipped, later ones shift out zeros behind the data.
   always_ff @(posedge CK_i or negedge XARST_i) begin
      if (!XARST_i) begin
         tx_q   <= '0;
         skip_q <= 1'b0;
      end else if (load_tx) begin
         tx_q   <= KEYS_i;
         skip_q <= 1'b1;
      end else if (shift_tx) begin
         if (skip_q) skip_q <= 1'b0;
         else        tx_q   <= {1'b0, tx_q[31:1]};
      end
   end

   assign DISP_RAM_o  = ram_q;
   assign bus.dio_oe  = (state_q == ST_RDATA);
   assign bus.dio_drv = (state_q == ST_RDATA) ? tx_q[0] : C_IDLE_DIO;

endmodule

// File: tb/tb_tm1638_slave_emu.sv
// tb_tm1638_slave_emu: drives TM1638 master frames into the emulator and compares its
// outputs with a frame-level model of the display RAM, mode and key readback.
module tb_tm1638_slave_emu;

   localparam int SYNC_STAGES = 2;
   localparam int HALF        = 8;

   logic          clock;
   logic          xarst;
   logic [31:0]   keysIn;
   logic [127:0]  dispRam;
   logic          dispOn;
   logic [2:0]    bright;
   logic          ramWr;
   logic [7:0]    cmdByte;
   logic          cmdVld;

   tm1638_slave_emu_if bus_if ();

   tm1638_slave_emu #(
      .C_SYNC_STAGES (SYNC_STAGES),
      .C_IDLE_DIO    (1'b1)
   ) dut (
      .CK_i       (clock),
      .XARST_i    (xarst),
      .bus        (bus_if),
      .KEYS_i     (keysIn),
      .DISP_RAM_o (dispRam),
      .DISP_ON_o  (dispOn),
      .BRIGHT_o   (bright),
      .RAM_WR_o   (ramWr),
      .CMD_o      (cmdByte),
      .CMD_VLD_o  (cmdVld)
   );

   int          checkCount;
   int          errorCount;
   int          wrPulses;
   int          vldPulses;
   int          wrBase;
   int          vldBase;
   int          expWr;
   int          expVld;

   logic [7:0]  frameBytes [0:31];
   logic [7:0]  modelRam [0:15];
   logic        modelRead;
   logic        modelFixed;
   int          modelAddr;
   logic        modelOn;
   logic [2:0]  modelBright;
   logic [7:0]  modelCmd;

   // Free-running system clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Count strobe pulses, sampled away from the active edge.
   always @(negedge clock) begin
      if (ramWr === 1'b1)  wrPulses  <= wrPulses + 1;
      if (cmdVld === 1'b1) vldPulses <= vldPulses + 1;
   end

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   function automatic logic [127:0] packRam();
      logic [127:0] r;
      for (int a = 0; a < 16; a++) r[8*a +: 8] = modelRam[a];
      return r;
   endfunction

   task automatic modelReset();
      for (int a = 0; a < 16; a++) modelRam[a] = 8'h00;
      modelRead   = 1'b0;
      modelFixed  = 1'b0;
      modelAddr   = 0;
      modelOn     = 1'b0;
      modelBright = 3'd0;
      modelCmd    = 8'h00;
   endtask

   // Frame-level reference: the first byte selects the command, later bytes are RAM data.
   task automatic modelFrame(input int n);
      logic [7:0] c;
      expWr  = 0;
      expVld = 0;
      if (n > 0) begin
         c        = frameBytes[0];
         expVld   = 1;
         modelCmd = c;
         case (c[7:6])
            2'b01: begin
               modelRead  = c[1];
               modelFixed = c[2];
            end
            2'b10: begin
               modelOn     = c[3];
               modelBright = c[2:0];
            end
            2'b11: begin
               modelAddr = int'(c[3:0]);
               for (int i = 1; i < n; i++) begin
                  expVld++;
                  modelCmd = frameBytes[i];
                  if (!modelRead) begin
                     modelRam[modelAddr] = frameBytes[i];
                     expWr++;
                     if (!modelFixed) modelAddr = (modelAddr + 1) % 16;
                  end
               end
            end
            default: ;
         endcase
      end
   endtask

   task automatic startFrame();
      wrBase  = wrPulses;
      vldBase = vldPulses;
      bus_if.stb = 1'b0;
      waitCycles(HALF);
   endtask

   task automatic sendBits(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         bus_if.sclk = 1'b0;
         bus_if.dio  = b[i];
         waitCycles(HALF);
         bus_if.sclk = 1'b1;
         waitCycles(HALF);
      end
   endtask

   task automatic endFrame();
      bus_if.stb = 1'b1;
      bus_if.dio = 1'b1;
      waitCycles(2 * HALF);
   endtask

   task automatic checkFrame(input string tag);
      checkOutput({tag, " ram"},    dispRam, packRam());
      checkOutput({tag, " dispOn"}, 128'(dispOn), 128'(modelOn));
      checkOutput({tag, " bright"}, 128'(bright), 128'(modelBright));
      checkOutput({tag, " cmd"},    128'(cmdByte), 128'(modelCmd));
      checkOutput({tag, " ramWr"},  128'(wrPulses - wrBase), 128'(expWr));
      checkOutput({tag, " cmdVld"}, 128'(vldPulses - vldBase), 128'(expVld));
   endtask

   // Send frameBytes[0..n-1] as one complete frame, then compare against the model.
   task automatic applyStimulus(input int n, input string tag);
      startFrame();
      for (int i = 0; i < n; i++) sendBits(frameBytes[i], 8);
      endFrame();
      modelFrame(n);
      checkFrame(tag);
   endtask

   // Key read frame: 33 clocks after the command, keys changed after the latch point.
   task automatic readKeys(input logic [7:0] cmd, input logic [31:0] keys, input string tag);
      logic [31:0] rx;
      logic        extraBad;
      logic        oeBad;
      rx       = '0;
      extraBad = 1'b0;
      oeBad    = 1'b0;
      keysIn   = keys;
      frameBytes[0] = cmd;
      startFrame();
      sendBits(cmd, 8);
      keysIn = ~keys;
      for (int k = 0; k < 33; k++) begin
         bus_if.sclk = 1'b0;
         waitCycles(HALF);
         if (k < 32) rx[k] = bus_if.dio_drv;
         else        extraBad = extraBad | bus_if.dio_drv;
         oeBad = oeBad | !bus_if.dio_oe;
         bus_if.sclk = 1'b1;
         waitCycles(HALF);
      end
      bus_if.stb = 1'b1;
      bus_if.dio = 1'b1;
      waitCycles(SYNC_STAGES + 1);
      checkOutput({tag, " oeDrop"},  128'(bus_if.dio_oe), 128'(1'b0));
      checkOutput({tag, " idleDio"}, 128'(bus_if.dio_drv), 128'(1'b1));
      waitCycles(2 * HALF);
      modelFrame(1);
      for (int b = 0; b < 4; b++)
         checkOutput($sformatf("%s byte%0d", tag, b), 128'(rx[8*b +: 8]), 128'(keys[8*b +: 8]));
      checkOutput({tag, " zeroTail"}, 128'(extraBad), 128'(1'b0));
      checkOutput({tag, " oeHeld"},   128'(oeBad), 128'(1'b0));
      checkFrame(tag);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, " ram"},    dispRam, 128'(0));
      checkOutput({tag, " dispOn"}, 128'(dispOn), 128'(1'b0));
      checkOutput({tag, " bright"}, 128'(bright), 128'(3'd0));
      checkOutput({tag, " oe"},     128'(bus_if.dio_oe), 128'(1'b0));
      checkOutput({tag, " dio"},    128'(bus_if.dio_drv), 128'(1'b1));
      checkOutput({tag, " ramWr"},  128'(ramWr), 128'(1'b0));
      checkOutput({tag, " cmd"},    128'(cmdByte), 128'(8'h00));
      checkOutput({tag, " cmdVld"}, 128'(cmdVld), 128'(1'b0));
   endtask

   initial begin
      int op;
      int n;
      checkCount  = 0;
      errorCount  = 0;
      wrPulses    = 0;
      vldPulses   = 0;
      wrBase      = 0;
      vldBase     = 0;
      xarst       = 1'b1;
      keysIn      = '0;
      bus_if.stb  = 1'b1;
      bus_if.sclk = 1'b1;
      bus_if.dio  = 1'b1;
      modelReset();

      waitCycles(1);
      xarst = 1'b0;
      waitCycles(3);
      checkResetValues("reset");
      xarst = 1'b1;
      waitCycles(4);

      $display("[TB] sequential write of 16 bytes");
      frameBytes[0] = 8'h40;
      applyStimulus(1, "mode40");
      frameBytes[0] = 8'hC0;
      for (int i = 0; i < 16; i++) frameBytes[i+1] = 8'(i);
      applyStimulus(17, "seqWrite");
      checkOutput("seqWrite image", dispRam, 128'h0F0E0D0C0B0A09080706050403020100);

      $display("[TB] fixed-address write");
      frameBytes[0] = 8'h44;
      applyStimulus(1, "mode44");
      frameBytes[0] = 8'hC5;
      frameBytes[1] = 8'hAA;
      frameBytes[2] = 8'h55;
      applyStimulus(3, "fixedWrite");

      $display("[TB] address wrap");
      frameBytes[0] = 8'h40;
      applyStimulus(1, "mode40b");
      frameBytes[0] = 8'hCE;
      frameBytes[1] = 8'h11;
      frameBytes[2] = 8'h22;
      frameBytes[3] = 8'h33;
      applyStimulus(4, "wrapWrite");

      $display("[TB] display control");
      frameBytes[0] = 8'h8C;
      applyStimulus(1, "ctrl8C");

      $display("[TB] key read");
      readKeys(8'h42, 32'h8040_2001, "read42");

      $display("[TB] aborted data byte");
      frameBytes[0] = 8'h40;
      applyStimulus(1, "mode40c");
      frameBytes[0] = 8'hC3;
      startFrame();
      sendBits(8'hC3, 8);
      sendBits(8'hAB, 5);
      endFrame();
      modelFrame(1);
      checkFrame("abort");

      $display("[TB] randomized frames");
      for (int it = 0; it < 24; it++) begin
         op = $urandom_range(0, 4);
         case (op)
            0: begin
               frameBytes[0] = 8'h40 | 8'($urandom_range(0, 3) << 1);
               applyStimulus(1, $sformatf("rnd%0d data", it));
            end
            1: begin
               n = 1 + $urandom_range(0, 5);
               frameBytes[0] = 8'hC0 | 8'($urandom_range(0, 15));
               for (int i = 1; i < n; i++) frameBytes[i] = 8'($urandom);
               applyStimulus(n, $sformatf("rnd%0d write", it));
            end
            2: begin
               frameBytes[0] = 8'h80 | 8'($urandom_range(0, 15));
               applyStimulus(1, $sformatf("rnd%0d ctrl", it));
            end
            3: begin
               readKeys(8'h42 | 8'($urandom_range(0, 1) << 2), $urandom, $sformatf("rnd%0d read", it));
            end
            default: begin
               frameBytes[0] = 8'($urandom_range(0, 63));
               frameBytes[1] = 8'($urandom);
               applyStimulus(2, $sformatf("rnd%0d ignored", it));
            end
         endcase
      end

      $display("[TB] reset during a read");
      keysIn = 32'hDEAD_BEEF;
      startFrame();
      sendBits(8'h42, 8);
      sendBits(8'h00, 4);
      xarst = 1'b0;
      #1;
      checkResetValues("midReset");
      bus_if.stb  = 1'b1;
      bus_if.sclk = 1'b1;
      bus_if.dio  = 1'b1;
      waitCycles(4);
      xarst = 1'b1;
      waitCycles(4);
      modelReset();
      checkResetValues("postReset");

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
